screen_answer_checker: RTL and testbench

Player-side consumer of the four-screen LFSR generator. Each round it requests a fresh set of screens, latches the four 2-bit screen symbols and the main symbol, and derives the correct button. It then judges the player's next button press and counts stages and strikes until the bomb is defused or explodes. It sits between the screen generator (driving the generator's advance input) and the game-over/LED logic.

---
 rtl/defuse_pkg.sv | 17 +
 rtl/screen_answer_checker_if.sv | 13 +
 rtl/defuse_answer_decode.sv | 25 ++
 rtl/screen_answer_checker.sv | 113 +++++++++++
 tb/tb_screen_answer_checker.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/defuse_pkg.sv
// defuse_pkg: shared state encoding, screen sizing and the answer rule for the defuse game
package defuse_pkg;
    localparam int SCREEN_W = 2;
    localparam int NUM_SCREENS = 4;
    typedef enum logic [2:0] {IDLE, WAIT_SCREEN, ARMED, DEFUSED, EXPLODED} state_t;
    // Lowest matching screen wins; with no match the main symbol itself names the button
    function automatic logic [SCREEN_W-1:0] answer_of(
        input logic [SCREEN_W-1:0] first,
        input logic [SCREEN_W-1:0] second,
        input logic [SCREEN_W-1:0] third,
        input logic [SCREEN_W-1:0] fourth,
        input logic [SCREEN_W-1:0] main
    );
        return first == main ? 2'd0 : second == main ? 2'd1 : third == main ? 2'd2 :
               fourth == main ? 2'd3 : main;
    endfunction
endpackage

// File: rtl/screen_answer_checker_if.sv
// screen_answer_checker_if: screen bus between the LFSR generator and the answer checker
interface screen_answer_checker_if;
    import defuse_pkg::*;
    logic [SCREEN_W-1:0] first;
    logic [SCREEN_W-1:0] second;
    logic [SCREEN_W-1:0] third;
    logic [SCREEN_W-1:0] fourth;
    logic [SCREEN_W-1:0] main;
    logic screen_done;
    logic next_screen;
    modport master (output first, second, third, fourth, main, screen_done, input next_screen);
    modport slave (input first, second, third, fourth, main, screen_done, output next_screen);
endinterface

// File: rtl/defuse_answer_decode.sv
// defuse_answer_decode: answer rule on latched screens plus button edge and one-hot press check
module defuse_answer_decode
    import defuse_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic [NUM_SCREENS-1:0] btn,
    input  logic [SCREEN_W-1:0] first,
    input  logic [SCREEN_W-1:0] second,
    input  logic [SCREEN_W-1:0] third,
    input  logic [SCREEN_W-1:0] fourth,
    input  logic [SCREEN_W-1:0] main,
    output logic press_valid,
    output logic [1:0] press_idx,
    output logic [SCREEN_W-1:0] answer
);
    logic [NUM_SCREENS-1:0] btn_q;
    logic [NUM_SCREENS-1:0] edge_v;
    always_ff @(posedge clk) btn_q <= rst ? '0 : btn;
    assign edge_v = btn & ~btn_q;
    // Chords and presses made while another button is held never count
    assign press_valid = $onehot(edge_v) && $onehot(btn);
    assign press_idx = btn[1] ? 2'd1 : btn[2] ? 2'd2 : btn[3] ? 2'd3 : 2'd0;
    assign answer = answer_of(first, second, third, fourth, main);
endmodule

// File: rtl/screen_answer_checker.sv
// screen_answer_checker: requests screens, judges each press, counts stages and strikes to defuse or explode
module screen_answer_checker
    import defuse_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int MAX_STRIKES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    screen_answer_checker_if.slave scr,
    input  logic [NUM_SCREENS-1:0] btn,
    output logic [2:0] stage,
    output logic [1:0] strikes,
    output logic correct_pulse,
    output logic wrong_pulse,
    output logic defused,
    output logic exploded
);
    localparam logic [2:0] STAGE_MAX = 3'(STAGES);
    localparam logic [1:0] STRIKE_MAX = 2'(MAX_STRIKES);
    state_t state, state_n;
    logic [SCREEN_W-1:0] first_q, second_q, third_q, fourth_q, main_q;
    logic [2:0] stage_n;
    logic [1:0] strikes_n;
    logic cp_n, wp_n, ns_q, ns_n, cap;
    logic press_valid;
    logic [1:0] press_idx;
    logic [SCREEN_W-1:0] answer;

    defuse_answer_decode u_decode (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .first(first_q),
        .second(second_q),
        .third(third_q),
        .fourth(fourth_q),
        .main(main_q),
        .press_valid(press_valid),
        .press_idx(press_idx),
        .answer(answer)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            stage <= '0;
            strikes <= '0;
            correct_pulse <= 1'b0;
            wrong_pulse <= 1'b0;
            ns_q <= 1'b0;
            {first_q, second_q, third_q, fourth_q, main_q} <= '0;
        end else begin
            state <= state_n;
            stage <= stage_n;
            strikes <= strikes_n;
            correct_pulse <= cp_n;
            wrong_pulse <= wp_n;
            ns_q <= ns_n;
            if (cap) {first_q, second_q, third_q, fourth_q, main_q} <=
                {scr.first, scr.second, scr.third, scr.fourth, scr.main};
        end
    end

    always_comb begin
        state_n = state;
        stage_n = stage;
        strikes_n = strikes;
        cp_n = 1'b0;
        wp_n = 1'b0;
        ns_n = 1'b0;
        cap = 1'b0;
        case (state)
            IDLE: begin
                stage_n = '0;
                strikes_n = '0;
                state_n = start ? WAIT_SCREEN : IDLE;
                ns_n = start;
            end
            // A done flag seen while our own request is still out is stale
            WAIT_SCREEN: begin
                cap = scr.screen_done && !ns_q;
                state_n = cap ? ARMED : WAIT_SCREEN;
            end
            ARMED: begin
                if (press_valid && press_idx == answer) begin
                    stage_n = stage + 3'd1;
                    cp_n = 1'b1;
                    state_n = stage_n == STAGE_MAX ? DEFUSED : WAIT_SCREEN;
                    ns_n = stage_n != STAGE_MAX;
                end else if (press_valid) begin
                    strikes_n = strikes + 2'd1;
                    wp_n = 1'b1;
                    state_n = strikes_n == STRIKE_MAX ? EXPLODED : WAIT_SCREEN;
                    ns_n = strikes_n != STRIKE_MAX;
                end
            end
            default: begin
                if (start) begin
                    state_n = WAIT_SCREEN;
                    ns_n = 1'b1;
                    stage_n = '0;
                    strikes_n = '0;
                end
            end
        endcase
    end

    assign scr.next_screen = ns_q;
    assign defused = state == DEFUSED;
    assign exploded = state == EXPLODED;
endmodule

// File: tb/tb_screen_answer_checker.sv
// tb_screen_answer_checker: directed rounds with a scoreboard of expected pulse-cycle snapshots
module tb_screen_answer_checker;
    localparam int STAGES = 4;
    localparam int MAX_STRIKES = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [3:0] btn = '0;
    logic [2:0] stage;
    logic [1:0] strikes;
    logic correct_pulse, wrong_pulse, defused, exploded;
    int vectors = 0;
    int misses = 0;
    int st = 0;
    int sk = 0;
    logic [9:0] exp_q[$];

    screen_answer_checker_if scr();

    screen_answer_checker #(.STAGES(STAGES), .MAX_STRIKES(MAX_STRIKES)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .scr(scr),
        .btn(btn),
        .stage(stage),
        .strikes(strikes),
        .correct_pulse(correct_pulse),
        .wrong_pulse(wrong_pulse),
        .defused(defused),
        .exploded(exploded)
    );

    always #5 clk = ~clk;

    // Snapshot layout: {correct, wrong, next_screen, defused, exploded, stage[2:0], strikes[1:0]}
    always @(negedge clk) begin
        if (!rst && (correct_pulse || wrong_pulse || scr.next_screen)) begin
            logic [9:0] got, e;
            got = {correct_pulse, wrong_pulse, scr.next_screen, defused, exploded, stage, strikes};
            vectors++;
            if (exp_q.size() == 0) begin
                misses++;
                $display("FAIL unexpected_event: got %b, required no event", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    misses++;
                    $display("FAIL event: got %b, required %b", got, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            misses++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_game();
        st = 0;
        sk = 0;
        exp_q.push_back({3'b001, 2'b00, 3'd0, 2'd0});
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic give(input logic [1:0] a, b, c, d, m);
        tick(1);
        {scr.first, scr.second, scr.third, scr.fourth, scr.main} = {a, b, c, d, m};
        scr.screen_done = 1'b1;
        tick(1);
        scr.screen_done = 1'b0;
    endtask

    task automatic press(input int p);
        btn = 4'(1 << p);
        tick(1);
        btn = '0;
        tick(1);
    endtask

    task automatic expect_press(input int ans, input int p);
        if (p == ans) begin
            st++;
            exp_q.push_back({2'b10, st != STAGES, st == STAGES, 1'b0, 3'(st), 2'(sk)});
        end else begin
            sk++;
            exp_q.push_back({2'b01, sk != MAX_STRIKES, 1'b0, sk == MAX_STRIKES, 3'(st), 2'(sk)});
        end
    endtask

    task automatic round(input logic [1:0] a, b, c, d, m, input int ans, input int p);
        give(a, b, c, d, m);
        expect_press(ans, p);
        press(p);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_strikes"}, strikes, 0);
        chk({tag, "_pulses"}, {correct_pulse, wrong_pulse, scr.next_screen}, 0);
        chk({tag, "_levels"}, {defused, exploded}, 0);
    endtask

    initial begin
        {scr.first, scr.second, scr.third, scr.fourth, scr.main, scr.screen_done} = '0;
        tick(3);
        rst = 1'b0;
        check_idle_outputs("reset");
        btn = 4'b0001;
        tick(1);
        btn = '0;
        tick(2);
        start_game();
        round(2'd2, 2'd1, 2'd1, 2'd0, 2'd1, 1, 1);
        round(2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 1, 3);
        round(2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 0, 0);
        // Chord 0011 in ARMED must be ignored, then the real answer is index 3
        give(2'd1, 2'd2, 2'd3, 2'd0, 2'd0);
        btn = 4'b0011;
        tick(1);
        btn = '0;
        tick(3);
        chk("chord_stage", stage, 2);
        expect_press(3, 3);
        press(3);
        // Correct button held from WAIT_SCREEN into ARMED must not score
        btn = 4'b0100;
        give(2'd0, 2'd1, 2'd2, 2'd3, 2'd2);
        tick(3);
        chk("held_stage", stage, 3);
        btn = '0;
        tick(1);
        expect_press(2, 2);
        press(2);
        chk("defused_level", {defused, exploded}, 2'b10);
        press(0);
        tick(2);
        chk("defused_hold_stage", stage, 4);
        start_game();
        tick(1);
        chk("restart_levels", {defused, exploded}, 0);
        round(2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2, 0);
        round(2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 3, 2);
        round(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 1);
        chk("exploded_level", {defused, exploded}, 2'b01);
        chk("exploded_strikes", strikes, 3);
        start_game();
        chk("restart2_exploded", exploded, 0);
        chk("restart2_strikes", strikes, 0);
        // Done flag raised during the next_screen cycle is stale; buttons stay ignored
        {scr.first, scr.second, scr.third, scr.fourth, scr.main} = {2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        scr.screen_done = 1'b1;
        tick(1);
        scr.screen_done = 1'b0;
        press(1);
        tick(2);
        chk("stale_stage", stage, 0);
        round(2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 1, 1);
        round(2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2, 2);
        give(2'd0, 2'd1, 2'd2, 2'd3, 2'd0);
        chk("pre_rst_stage", stage, 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_idle_outputs("mid_rst");
        press(0);
        tick(2);
        chk("post_rst_stage", stage, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
